// File: rtl/pakdsp_pkg.sv
// pakdsp_pkg: shared constants and SPI bridge state encoding for the Pak-DSP register path.
package pakdsp_pkg;
   localparam int SPI_HDR_BITS = 8;
   localparam int SPI_WR_BIT = 7;
   typedef enum logic [2:0] {WAIT_CS, IDLE, HEADER, LOAD, READ_DATA, WRITE_DATA, COMMIT} spi_state_e;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer with rise/fall pulses taken from the last stage.
module sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync;
   logic prev;
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         prev <= sync[STAGES-1];
      end
   assign rise = sync[STAGES-1] & ~prev;
   assign fall = ~sync[STAGES-1] & prev;
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave turning header+payload frames into single-cycle
// register reads/writes on the memory-map port; SPI pins are oversampled in clk.
module spi_reg_bridge
   import pakdsp_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  write_en,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  frame_err
);
   localparam int FRAME_BITS = SPI_HDR_BITS + DATA_WIDTH;
   localparam int CW = $clog2(FRAME_BITS) + 1;
   localparam logic [CW-1:0] HDR_LAST   = CW'(SPI_HDR_BITS - 1);
   localparam logic [CW-1:0] HDR_N      = CW'(SPI_HDR_BITS);
   localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);

   spi_state_e state, nxt_state;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [DATA_WIDTH-1:0] sh, nxt_sh, shifted, nxt_wdata;
   logic [ADDR_WIDTH-1:0] nxt_addr;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic nxt_we, nxt_miso, nxt_oe, nxt_busy, nxt_err;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_hi, mosi;

   sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk (
      .clk(clk), .arst_n(arst_n), .d(spi_sclk), .rise(sclk_rise), .fall(sclk_fall));
   sync_edge_det #(.STAGES(SYNC_STAGES)) u_cs (
      .clk(clk), .arst_n(arst_n), .d(spi_cs_n), .rise(cs_rise), .fall(cs_fall));

   assign mosi = mosi_sync[SYNC_STAGES-1];
   assign shifted = {sh[DATA_WIDTH-2:0], mosi};

   // Synced chip-select level, tracked from its edges so WAIT_CS can leave on a high cs_n.
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         mosi_sync <= '0;
         cs_hi <= 1'b0;
      end else begin
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_hi <= cs_rise ? 1'b1 : cs_fall ? 1'b0 : cs_hi;
      end

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         state <= WAIT_CS;
         cnt <= '0;
         sh <= '0;
         addr <= '0;
         wdata <= '0;
         write_en <= 1'b0;
         spi_miso <= 1'b0;
         spi_miso_oe <= 1'b0;
         busy <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt <= nxt_cnt;
         sh <= nxt_sh;
         addr <= nxt_addr;
         wdata <= nxt_wdata;
         write_en <= nxt_we;
         spi_miso <= nxt_miso;
         spi_miso_oe <= nxt_oe;
         busy <= nxt_busy;
         frame_err <= nxt_err;
      end

   always_comb begin
      nxt_state = state;
      nxt_cnt = cnt;
      nxt_sh = sh;
      nxt_addr = addr;
      nxt_wdata = wdata;
      nxt_we = 1'b0;
      nxt_miso = spi_miso;
      nxt_oe = spi_miso_oe;
      nxt_busy = busy;
      nxt_err = 1'b0;
      if (cs_rise && state inside {HEADER, LOAD, READ_DATA, WRITE_DATA}) begin
         nxt_state = IDLE;
         nxt_err = 1'b1;
         nxt_oe = 1'b0;
         nxt_miso = 1'b0;
         nxt_busy = 1'b0;
      end else
         case (state)
            WAIT_CS: if (cs_hi) begin
               nxt_state = IDLE;
               nxt_busy = 1'b0;
            end
            IDLE: if (cs_fall) begin
               nxt_state = HEADER;
               nxt_cnt = '0;
               nxt_busy = 1'b1;
            end
            HEADER: if (sclk_rise) begin
               nxt_sh = shifted;
               nxt_cnt = cnt + 1'b1;
               if (cnt == HDR_LAST) begin
                  nxt_addr = shifted[ADDR_WIDTH-1:0];
                  nxt_state = shifted[SPI_WR_BIT] ? WRITE_DATA : LOAD;
               end
            end
            LOAD: begin
               nxt_sh = rdata;
               nxt_miso = rdata[DATA_WIDTH-1];
               nxt_oe = 1'b1;
               nxt_state = READ_DATA;
            end
            // The MSB is already on miso at the 8th fall, so shifting starts at the 9th.
            READ_DATA: if (sclk_rise) begin
               nxt_cnt = cnt + 1'b1;
               if (cnt == FRAME_LAST) begin
                  nxt_state = WAIT_CS;
                  nxt_oe = 1'b0;
                  nxt_miso = 1'b0;
               end
            end else if (sclk_fall && cnt > HDR_N) begin
               nxt_sh = sh << 1;
               nxt_miso = sh[DATA_WIDTH-2];
            end
            WRITE_DATA: if (sclk_rise) begin
               nxt_sh = shifted;
               nxt_cnt = cnt + 1'b1;
               if (cnt == FRAME_LAST) nxt_state = COMMIT;
            end
            COMMIT: begin
               nxt_wdata = sh;
               nxt_we = 1'b1;
               nxt_state = WAIT_CS;
            end
            default: nxt_state = WAIT_CS;
         endcase
   end
endmodule
